// File: rtl/pdm_cic_interpolator.sv
// pdm_cic_interpolator
//
// Upsamples a 4-bit unsigned PCM stream by 4 through a two-stage CIC
// interpolator, then converts the interpolated value to a 1-bit pulse-density
// stream with a first-order modulator. A sample is taken once every four
// cycles, in the cycle where sample_ready is high. If the producer misses one
// of those slots after it has started streaming, the last sample is repeated
// and a sticky underrun flag is raised.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   sample_in     unsigned PCM sample, 0..15
//   sample_valid  sample_in is valid; only looked at while sample_ready is high
//   sample_ready  high in the one cycle of every four where a sample is taken
//   pdm_out       registered pulse-density output; density = sample / 16
//   underrun      sticky: a slot went by without a sample after streaming began
module pdm_cic_interpolator #(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned UPSAMPLING = 4,
  parameter int unsigned WIDTH_IN   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH_IN-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pdm_out,
  output logic                underrun
);

  // Datapath width of the CIC. With N=2, R=4 and a 4-bit input the true
  // signal never leaves 0..60, so 8-bit wrapping arithmetic is exact.
  localparam int unsigned CicW = 8;
  localparam int unsigned AccW = 7;
  // Modulator threshold: full scale of y (60) maps to 60/64 = 15/16 density.
  localparam logic [CicW-1:0] Thresh = 8'd64;

  if (STAGES != 2 || UPSAMPLING != 4 || WIDTH_IN != 4) begin : g_param_check
    $error("pdm_cic_interpolator supports only STAGES=2, UPSAMPLING=4, WIDTH_IN=4");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          ctr_q, ctr_d;
  logic [WIDTH_IN-1:0] x_reg_q, x_reg_d;
  logic [CicW-1:0]     d0_q, d0_d;
  logic [CicW-1:0]     d1_q, d1_d;
  logic [CicW-1:0]     cout_q, cout_d;
  logic [CicW-1:0]     i1_q, i1_d;
  logic [CicW-1:0]     i2_q, i2_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic                armed_q, armed_d;
  logic                underrun_q, underrun_d;
  logic                pdm_q, pdm_d;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic                slot;
  logic [WIDTH_IN-1:0] x_eff;
  logic [CicW-1:0]     x_ext;
  logic [CicW-1:0]     c0;
  logic [CicW-1:0]     c1;
  logic [CicW-1:0]     u;
  logic [AccW-1:0]     y;
  logic [CicW-1:0]     sum;
  logic                over;
  logic                unused_i2_msb;

  assign slot = (ctr_q == 2'd3);

  // A missed slot repeats the previous sample rather than inserting a zero,
  // which would otherwise show up as a click in the output.
  assign x_eff = sample_valid ? sample_in : x_reg_q;
  assign x_ext = CicW'(x_eff);

  // Comb section, evaluated at the low rate (only committed on slot edges).
  assign c0 = x_ext - d0_q;
  assign c1 = c0 - d1_q;

  // Zero-stuffing: the comb output enters the integrators in the first
  // high-rate cycle after the slot edge that produced it.
  assign u = (ctr_q == 2'd0) ? cout_q : '0;

  // i2 stays within 0..60, so bit 7 carries no information.
  assign y             = i2_q[AccW-1:0];
  assign unused_i2_msb = i2_q[CicW-1];

  // acc is always below 64 and y at most 60, so the sum fits in 7 bits; one
  // extra bit keeps the comparison simple.
  assign sum  = CicW'(acc_q) + CicW'(y);
  assign over = (sum >= Thresh);

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    ctr_d      = ctr_q + 2'd1;
    x_reg_d    = x_reg_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    cout_d     = cout_q;
    armed_d    = armed_q;
    underrun_d = underrun_q;

    if (slot) begin
      d0_d   = x_ext;
      d1_d   = c0;
      cout_d = c1;
      if (sample_valid) begin
        x_reg_d = sample_in;
        armed_d = 1'b1;
      end else if (armed_q) begin
        // Silence before the first sample is not an underrun; only a gap
        // after streaming has started is.
        underrun_d = 1'b1;
      end
    end

    // Integrators run at the high rate; i2 accumulates the old i1.
    i1_d = i1_q + u;
    i2_d = i2_q + i1_q;

    pdm_d = over;
    acc_d = over ? AccW'(sum - Thresh) : sum[AccW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q      <= '0;
      x_reg_q    <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      cout_q     <= '0;
      i1_q       <= '0;
      i2_q       <= '0;
      acc_q      <= '0;
      armed_q    <= 1'b0;
      underrun_q <= 1'b0;
      pdm_q      <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      x_reg_q    <= x_reg_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      cout_q     <= cout_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      acc_q      <= acc_d;
      armed_q    <= armed_d;
      underrun_q <= underrun_d;
      pdm_q      <= pdm_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sample_ready = slot;
  assign pdm_out      = pdm_q;
  assign underrun     = underrun_q;

endmodule

// File: doc/pdm_cic_interpolator.md
PDM_CIC_INTERPOLATOR -- requirements
Module: pdm_cic_interpolator

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of comb and integrator stages (only 2 is supported).
REQ-002 SHALL have parameter UPSAMPLING, default 4, interpolation ratio R (only 4 is supported).
REQ-003 SHALL have parameter WIDTH_IN, default 4, unsigned input sample width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge clocked.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sample_in, input, 4 bits: unsigned PCM sample, 0..15.
REQ-007 SHALL have port sample_valid, input, 1 bit: sample_in is valid.
REQ-008 SHALL have port sample_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port pdm_out, output, 1 bit: registered 1-bit pulse-density output.
REQ-010 SHALL have port underrun, output, 1 bit: sticky flag for a missed sample slot.

Function
REQ-011 SHALL keep a 2-bit phase counter ctr that increments every cycle and wraps from 3 to 0.
REQ-012 SHALL drive sample_ready = (ctr == 3) combinationally; the slot is that cycle.
REQ-013 SHALL transfer a sample on a slot edge when sample_valid = 1: x_eff = sample_in, and x_reg <= sample_in.
REQ-014 SHALL use x_eff = x_reg (hold and repeat) on a slot edge with sample_valid = 0; sample_valid outside a slot SHALL be ignored.
REQ-015 SHALL update the comb section on every slot edge only, using 8-bit two's-complement wrap arithmetic: c0 = x_eff - d0, c1 = c0 - d1; d0 <= x_eff, d1 <= c0, cout <= c1.
REQ-016 SHALL zero-stuff the integrator input: u = cout when ctr == 0, else 0.
REQ-017 SHALL update the integrators every cycle, 8-bit, wrapping: i1 <= i1 + u, i2 <= i2 + i1 (i2 uses the old i1).
REQ-018 SHALL take y = i2[6:0] as unsigned; y SHALL stay within 0..60, with a DC gain of 4.
REQ-019 SHALL run a first-order modulator every cycle with a 7-bit accumulator acc: sum = acc + y; pdm_out <= (sum >= 64); acc <= sum - 64 when sum >= 64, else acc <= sum.
REQ-020 SHALL make the steady-state density of pdm_out exactly x/16, i.e. 4x ones per 64 cycles.
REQ-021 SHALL arm underrun detection on the first accepted transfer after reset.
REQ-022 SHALL set underrun, once armed, on any slot edge with sample_valid = 0.
REQ-023 SHALL leave underrun set until reset; a later valid sample SHALL NOT clear it.
REQ-024 SHALL, on the first pdm_out edge after a step from 0 to 15 out of reset, raise pdm_out 5 edges after the accepting edge.

Reset
REQ-025 SHALL, while rst = 1, asynchronously clear ctr, x_reg, d0, d1, cout, i1, i2, acc, the underrun arm bit, underrun and pdm_out to 0.
REQ-026 SHALL hold sample_ready = 0 during reset, and for the first 3 cycles after release; the first slot is the 4th cycle.
REQ-027 SHALL treat a reset asserted mid-stream as a full restart, with no residual density from the previous stream.

Verification
REQ-028 Reset release, sample_valid = 1 with 15 at the first slot -> sample_ready high in cycle 4; i2 sequence 0, 15, 30, 45, 60, then holds 60; pdm_out first rises 5 edges after the accept.
REQ-029 Constant sample 8 at every slot -> after settling, pdm_out alternates 1, 0 with exactly 32 ones per 64 cycles.
REQ-030 Constant sample 0 -> pdm_out stays 0 indefinitely; constant 15 -> exactly 60 ones in every 64-cycle window after settling.
REQ-031 sample_valid held 0 from reset -> underrun stays 0; accept one sample, then drop valid at the next slot -> underrun = 1 the cycle after that slot; it stays 1 with valid restored; the output repeats the held sample at the same density.
REQ-032 sample_valid = 1 in cycles where ctr != 3 only -> no transfer, x_reg unchanged.
REQ-033 Stream at 15, assert rst for 1 cycle mid-period -> all outputs 0 immediately; after release the REQ-028 timing repeats exactly.
